// File: rtl/mem_access_unit_if.sv
// Signal bundle between the pipeline MEM stage, the data-memory bus and the
// load/store unit. Op request (op_*), memory bus (mem_*) and completion (rsp_*).
// Modport master is the load/store unit itself; slave is the environment
// (pipeline plus memory) that surrounds it.
interface mem_access_unit_if;
  // op request from the pipeline
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_type;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [31:0] op_pc;
  // word-addressed memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // completion back to the pipeline
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        rsp_timeout;
  logic [31:0] rsp_pc;

  modport master (
    input  op_valid, op_type, op_addr, op_wdata, op_pc, mem_ack, mem_rdata,
    output op_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_misalign, rsp_timeout, rsp_pc
  );

  modport slave (
    output op_valid, op_type, op_addr, op_wdata, op_pc, mem_ack, mem_rdata,
    input  op_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_misalign, rsp_timeout, rsp_pc
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: one op from MEM stage -> word bus cycle -> extended load result.
// Latency: bus request the cycle after accept, rsp_valid the cycle after the ack edge (k+2 per op).
// Backpressure: op_ready only in IDLE; rsp_valid is a single-cycle pulse with no backpressure.
//
// Ports: clk, reset (synchronous, active-high) and the mem_access_unit_if master
// view: op_valid/op_ready/op_type/op_addr/op_wdata/op_pc in, mem_req/mem_we/mem_addr/
// mem_be/mem_wdata out with mem_ack/mem_rdata back, rsp_valid/rsp_rdata/rsp_misalign/
// rsp_timeout/rsp_pc out.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16,  // max cycles mem_req stays high without ack (>=1)
  parameter int CNT_W       = 8    // wait counter width, must hold TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       type_q;
  logic [1:0]       off_q;      // byte offset of the op, selects the load lane
  logic [CNT_W-1:0] cnt;

  logic             misalign;
  logic             is_store;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;
  logic             timeout_hit;

  // Decode of the op presented in IDLE.
  always_comb begin
    misalign  = 1'b0;
    is_store  = 1'b0;
    be_nxt    = 4'b0000;
    wdata_nxt = bus.op_wdata;
    case (bus.op_type)
      OP_LW:  misalign = (bus.op_addr[1:0] != 2'b00);
      OP_LH,
      OP_LHU: misalign = bus.op_addr[0];
      OP_SW: begin
        misalign = (bus.op_addr[1:0] != 2'b00);
        is_store = 1'b1;
        be_nxt   = 4'b1111;
      end
      OP_SH: begin
        misalign  = bus.op_addr[0];
        is_store  = 1'b1;
        be_nxt    = 4'b0011 << bus.op_addr[1:0];
        wdata_nxt = {2{bus.op_wdata[15:0]}};
      end
      OP_SB: begin
        is_store  = 1'b1;
        be_nxt    = 4'b0001 << bus.op_addr[1:0];
        wdata_nxt = {4{bus.op_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of the returned read word.
  always_comb begin
    byte_sel = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext = bus.mem_rdata;
    case (type_q)
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.op_ready  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) state_nxt = misalign ? RESP : BUS;
      end
      BUS: begin
        bus.mem_req = 1'b1;
        // ack takes priority over a timeout on the same edge
        if (bus.mem_ack || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus command is captured at accept and stays stable for the whole bus cycle;
  // response fields are written on entry to RESP and hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      type_q           <= 3'd0;
      off_q            <= 2'd0;
      cnt              <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= 32'h0;
      bus.mem_be       <= 4'b0000;
      bus.mem_wdata    <= 32'h0;
      bus.rsp_rdata    <= 32'h0;
      bus.rsp_misalign <= 1'b0;
      bus.rsp_timeout  <= 1'b0;
      bus.rsp_pc       <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            type_q        <= bus.op_type;
            off_q         <= bus.op_addr[1:0];
            cnt           <= '0;
            bus.mem_we    <= is_store;
            bus.mem_addr  <= {bus.op_addr[31:2], 2'b00};
            bus.mem_be    <= be_nxt;
            bus.mem_wdata <= wdata_nxt;
            bus.rsp_pc    <= bus.op_pc;
            if (misalign) begin
              bus.rsp_rdata    <= 32'h0;
              bus.rsp_misalign <= 1'b1;
              bus.rsp_timeout  <= 1'b0;
            end
          end
        end
        BUS: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.mem_ack) begin
            bus.rsp_rdata    <= bus.mem_we ? 32'h0 : load_ext;
            bus.rsp_misalign <= 1'b0;
            bus.rsp_timeout  <= 1'b0;
          end else if (timeout_hit) begin
            bus.rsp_rdata    <= 32'h0;
            bus.rsp_misalign <= 1'b0;
            bus.rsp_timeout  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads with lane extension, stores with byte
// enables and replicated data, misalignment, timeout, ack/timeout tie and reset mid-bus.
module tb_mem_access_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op at the current negedge; returns at the next negedge (first BUS cycle).
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] pc);
    check("op_ready_before_issue", {31'd0, bus.op_ready}, 32'd1);
    bus.op_valid = 1'b1;
    bus.op_type  = t;
    bus.op_addr  = a;
    bus.op_wdata = w;
    bus.op_pc    = pc;
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  // Called in the first BUS cycle; ack is sampled on the k-th edge after accept.
  // Returns at the negedge of the RESP cycle.
  task automatic ack_after(input int k, input logic [31:0] rd);
    for (int i = 1; i < k; i++) @(negedge clk);
    check("req_held_before_ack", {31'd0, bus.mem_req}, 32'd1);
    check("no_rsp_before_ack", {31'd0, bus.rsp_valid}, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
    issue(t, a, 32'h5555_5555, a + 32'h1000);
    check({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    check({tag, "_be"}, {28'd0, bus.mem_be}, 32'd0);
    check({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    ack_after(2, rd);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, "_rdata"}, bus.rsp_rdata, exp);
    @(negedge clk);
    check({tag, "_rsp_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic store_case(input string tag, input logic [2:0] t, input logic [31:0] a,
                            input logic [31:0] w, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
    issue(t, a, w, 32'h0000_2000);
    check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
    check({tag, "_we"}, {31'd0, bus.mem_we}, 32'd1);
    check({tag, "_be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
    check({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    check({tag, "_wdata"}, bus.mem_wdata, exp_wd);
    ack_after(1, 32'hFFFF_FFFF);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, "_rdata_zero"}, bus.rsp_rdata, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    int seen;

    bus.op_valid  = 1'b0;
    bus.op_type   = 3'd0;
    bus.op_addr   = 32'h0;
    bus.op_wdata  = 32'h0;
    bus.op_pc     = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);

    // 1: LW with ack three edges after accept
    issue(3'd0, 32'h0000_0100, 32'h0, 32'h0000_0440);
    check("lw_req", {31'd0, bus.mem_req}, 32'd1);
    check("lw_be", {28'd0, bus.mem_be}, 32'd0);
    check("lw_addr", bus.mem_addr, 32'h0000_0100);
    ack_after(3, 32'hDEAD_BEEF);
    check("lw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("lw_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("lw_pc", bus.rsp_pc, 32'h0000_0440);
    check("lw_flags", {30'd0, bus.rsp_misalign, bus.rsp_timeout}, 32'd0);
    check("lw_req_dropped", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check("lw_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // 2: sub-word loads and extension
    load_case("lb_103",  3'd3, 32'h0000_0103, 32'h8011_2233, 32'hFFFF_FF80);
    load_case("lbu_103", 3'd4, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080);
    load_case("lh_102",  3'd1, 32'h0000_0102, 32'h8011_2233, 32'hFFFF_8011);
    load_case("lhu_102", 3'd2, 32'h0000_0102, 32'h8011_2233, 32'h0000_8011);
    load_case("lb_100",  3'd3, 32'h0000_0100, 32'h8011_22B3, 32'hFFFF_FFB3);
    load_case("lh_100",  3'd1, 32'h0000_0100, 32'h8011_2233, 32'h0000_2233);

    // 3: stores
    store_case("sb_102", 3'd7, 32'h0000_0102, 32'h0000_00AB, 4'b0100, 32'hABAB_ABAB);
    store_case("sh_102", 3'd6, 32'h0000_0102, 32'h1234_CAFE, 4'b1100, 32'hCAFE_CAFE);
    store_case("sw_104", 3'd5, 32'h0000_0104, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // mem_ack while idle is ignored
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idle_ack_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check("idle_ack_ready", {31'd0, bus.op_ready}, 32'd1);

    // 4: misaligned LW, no bus cycle
    issue(3'd0, 32'h0000_0101, 32'h0, 32'h0000_0ABC);
    check("mis_no_req", {31'd0, bus.mem_req}, 32'd0);
    check("mis_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("mis_flag", {31'd0, bus.rsp_misalign}, 32'd1);
    check("mis_pc", bus.rsp_pc, 32'h0000_0ABC);
    check("mis_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    check("mis_back_idle", {31'd0, bus.op_ready}, 32'd1);

    // 5: SW with no ack -> timeout after exactly 16 request cycles
    issue(3'd5, 32'h0000_0200, 32'h0BAD_F00D, 32'h0000_0500);
    req_cycles = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
      if (bus.mem_req) req_cycles++;
      @(negedge clk);
    end
    check("to_rsp_seen", seen, 32'd1);
    check("to_req_cycles", req_cycles, 32'd16);
    check("to_flag", {31'd0, bus.rsp_timeout}, 32'd1);
    check("to_misalign_clear", {31'd0, bus.rsp_misalign}, 32'd0);
    check("to_req_dropped", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check("to_back_idle", {31'd0, bus.op_ready}, 32'd1);

    // ack on the same edge as the timeout: ack wins
    issue(3'd0, 32'h0000_0300, 32'h0, 32'h0000_0600);
    ack_after(16, 32'hCAFE_0001);
    check("tie_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("tie_no_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    check("tie_rdata", bus.rsp_rdata, 32'hCAFE_0001);
    @(negedge clk);

    // 6: reset two cycles into BUS
    issue(3'd5, 32'h0000_0400, 32'h1111_2222, 32'h0000_0700);
    @(negedge clk);
    check("rstbus_req_high", {31'd0, bus.mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstbus_req_low", {31'd0, bus.mem_req}, 32'd0);
    check("rstbus_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid || bus.mem_req) seen = 1;
      @(negedge clk);
    end
    check("rstbus_quiet", seen, 32'd0);
    check("rstbus_ready", {31'd0, bus.op_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
